// File: rtl/game_pkg.sv
// Shared encodings and widths for the round sequencer and its helpers.
package game_pkg;

  localparam int STATE_W = 3;
  localparam int TIME_W  = 8;
  localparam int TASK_W  = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_WALK = 3'd1,
    ST_TASK = 3'd2,
    ST_WIN  = 3'd3,
    ST_LOSE = 3'd4
  } state_t;

endpackage

// File: rtl/game_flow_fsm_tick_prescaler.sv
// Divide-by-DIV counter with enable and synchronous clear; emits a
// one-cycle tick on the last count while enabled. Holds when disabled.
module tick_prescaler #(
  parameter int unsigned DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] count;

  assign tick = en && (count == LAST);

  // Wrap at DIV-1 while enabled; clear wins over counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/game_flow_fsm.sv
// Round sequencer: countdown timer, door/seat dwell qualification and
// win/lose decision. All outputs are registered alongside the state.
//
//   state | meaning
//   IDLE  | after reset, waiting for start
//   WALK  | sprite moving, timer running, dwell watched
//   TASK  | task screen shown, timer still running
//   WIN   | seat reached with enough tasks done
//   LOSE  | countdown expired
module game_flow_fsm
  import game_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 25_000_000,
  parameter int unsigned TIME_LIMIT   = 60,
  parameter int unsigned DWELL_CYCLES = 8,
  parameter int unsigned TASKS_REQ    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_door,
  input  logic               in_seat,
  input  logic               task_done,
  output logic               sprite_en,
  output logic               task_enable,
  output logic [TIME_W-1:0]  time_left,
  output logic [TASK_W-1:0]  tasks_completed,
  output logic               win,
  output logic               lose,
  output logic [STATE_W-1:0] state_o
);

  localparam logic [TIME_W-1:0] TIME_INIT  = TIME_W'(TIME_LIMIT);
  localparam logic [7:0]        DWELL_LAST = 8'(DWELL_CYCLES - 1);
  localparam logic [7:0]        DWELL_MAX  = 8'(DWELL_CYCLES);
  localparam logic [TASK_W-1:0] TASK_NEED  = TASK_W'(TASKS_REQ);
  localparam logic [TASK_W-1:0] TASK_SAT   = '1;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  dwell;
  logic        door_armed;
  logic        running;
  logic        start_ok;
  logic        tick;
  logic        timeout;
  logic        seat_q;
  logic        door_q;
  logic        dwell_cond;
  logic        accept;

  assign running    = (state == ST_WALK) || (state == ST_TASK);
  assign start_ok   = start && ((state == ST_IDLE) || (state == ST_WIN) || (state == ST_LOSE));
  assign timeout    = tick && (time_left == TIME_W'(1));
  assign seat_q     = in_seat && (tasks_completed >= TASK_NEED);
  assign door_q     = in_door && door_armed;
  assign dwell_cond = (state == ST_WALK) && (seat_q || door_q);
  assign accept     = dwell_cond && (dwell == DWELL_LAST);
  assign state_o    = state;

  tick_prescaler #(
    .DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (running),
    .clr   (start_ok),
    .tick  (tick)
  );

  // Next-state selection; timeout outranks dwell acceptance and task_done.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_WIN, ST_LOSE: begin
        if (start) state_nxt = ST_WALK;
      end
      ST_WALK: begin
        if (timeout)     state_nxt = ST_LOSE;
        else if (accept) state_nxt = seat_q ? ST_WIN : ST_TASK;
      end
      ST_TASK: begin
        if (timeout)        state_nxt = ST_LOSE;
        else if (task_done) state_nxt = ST_WALK;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, round counters, dwell tracking and Moore outputs decoded from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      time_left       <= TIME_INIT;
      tasks_completed <= '0;
      dwell           <= '0;
      door_armed      <= 1'b1;
      sprite_en       <= 1'b0;
      task_enable     <= 1'b0;
      win             <= 1'b0;
      lose            <= 1'b0;
    end else begin
      state       <= state_nxt;
      sprite_en   <= (state_nxt == ST_WALK);
      task_enable <= (state_nxt == ST_TASK);
      win         <= (state_nxt == ST_WIN);
      lose        <= (state_nxt == ST_LOSE);

      if (dwell_cond) begin
        dwell <= (dwell == DWELL_MAX) ? DWELL_MAX : dwell + 8'd1;
      end else begin
        dwell <= '0;
      end

      if (tick && (time_left != '0)) begin
        time_left <= time_left - TIME_W'(1);
      end

      // Re-arm only once the sprite has stepped off the door.
      if ((state == ST_WALK) && !in_door) begin
        door_armed <= 1'b1;
      end

      if (start_ok) begin
        time_left       <= TIME_INIT;
        tasks_completed <= '0;
        dwell           <= '0;
        door_armed      <= 1'b1;
      end else if ((state == ST_WALK) && !timeout && accept && !seat_q) begin
        door_armed <= 1'b0;
      end else if ((state == ST_TASK) && !timeout && task_done) begin
        if (tasks_completed != TASK_SAT) begin
          tasks_completed <= tasks_completed + TASK_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_game_flow_fsm.sv
// Directed scenarios followed by random stimulus, every cycle compared
// against a round-level reference model.
module tb_game_flow_fsm;

  localparam int TICK_DIV  = 4;
  localparam int TLIM      = 10;
  localparam int DWELL     = 3;
  localparam int TASKS_REQ = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, in_door, in_seat, task_done;
  logic       sprite_en, task_enable, win, lose;
  logic [7:0] time_left;
  logic [3:0] tasks_completed;
  logic [2:0] state_o;

  int n_asserts = 0;
  int n_fail    = 0;

  // Model: phase 0 idle, 1 walking, 2 task, 3 won, 4 lost.
  int m_st, m_time, m_tasks, m_cyc, m_run;
  bit m_armed;

  game_flow_fsm #(
    .TICK_DIV     (TICK_DIV),
    .TIME_LIMIT   (TLIM),
    .DWELL_CYCLES (DWELL),
    .TASKS_REQ    (TASKS_REQ)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .in_door         (in_door),
    .in_seat         (in_seat),
    .task_done       (task_done),
    .sprite_en       (sprite_en),
    .task_enable     (task_enable),
    .time_left       (time_left),
    .tasks_completed (tasks_completed),
    .win             (win),
    .lose            (lose),
    .state_o         (state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_time = TLIM; m_tasks = 0; m_cyc = 0; m_run = 0; m_armed = 1;
  endtask

  // One clock of the round rules, using inputs as seen at the edge.
  task automatic model_step();
    bit tick, timeout, seat_ok, door_ok, accepted;
    tick = 0;
    if (m_st == 1 || m_st == 2) begin
      m_cyc++;
      tick = (m_cyc % TICK_DIV) == 0;
    end
    timeout = tick && (m_time == 1);
    seat_ok = in_seat && (m_tasks >= TASKS_REQ);
    door_ok = in_door && m_armed;
    if (m_st == 1 && (seat_ok || door_ok)) m_run++;
    else m_run = 0;
    accepted = (m_st == 1) && (m_run == DWELL);
    if (tick && m_time > 0) m_time--;
    if (m_st == 1 && !in_door) m_armed = 1;
    case (m_st)
      1: begin
        if (timeout) m_st = 4;
        else if (accepted) begin
          if (seat_ok) m_st = 3;
          else begin m_st = 2; m_armed = 0; end
        end
      end
      2: begin
        if (timeout) m_st = 4;
        else if (task_done) begin
          m_st = 1;
          if (m_tasks < 15) m_tasks++;
        end
      end
      default: begin
        if (start) begin
          m_st = 1; m_time = TLIM; m_tasks = 0; m_cyc = 0; m_run = 0; m_armed = 1;
        end
      end
    endcase
  endtask

  task automatic check_model();
    chk("state_o", state_o, m_st);
    chk("time_left", time_left, m_time);
    chk("tasks_completed", tasks_completed, m_tasks);
    chk("moore_outs", {sprite_en, task_enable, win, lose},
        {m_st == 1, m_st == 2, m_st == 3, m_st == 4});
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
    start = 0;
    task_done = 0;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  initial begin
    rst_n = 0; start = 0; in_door = 0; in_seat = 0; task_done = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    check_model();

    // Plain timeout: 10 ticks of 4 cycles each.
    start = 1; cycle();
    run(40);
    chk("t1_state_lose", state_o, 4);
    chk("t1_lose", lose, 1);
    chk("t1_sprite_off", sprite_en, 0);

    // Interrupted dwell, then full dwell into TASK.
    start = 1; cycle();
    in_door = 1; run(2);
    chk("t2_no_early", state_o, 1);
    in_door = 0; cycle();
    in_door = 1; run(2);
    chk("t2_still_walk", state_o, 1);
    cycle();
    chk("t2_task", state_o, 2);
    chk("t2_task_en", task_enable, 1);

    // Return with door still held: no re-entry until released.
    task_done = 1; cycle();
    chk("t3_walk", state_o, 1);
    chk("t3_tasks", tasks_completed, 1);
    run(3);
    chk("t3_no_reentry", state_o, 1);
    in_door = 0; cycle();
    in_door = 1; run(3);
    chk("t3_reentry", state_o, 2);
    in_door = 0; task_done = 1; cycle();
    run(40);
    chk("t3_timeout", state_o, 4);

    // Seat needs a task first.
    start = 1; cycle();
    in_seat = 1; run(10);
    chk("t4_seat_blocked", state_o, 1);
    in_seat = 0; in_door = 1; run(3);
    in_door = 0; task_done = 1; cycle();
    in_seat = 1; run(3);
    chk("t4_win_state", state_o, 3);
    chk("t4_win", win, 1);
    in_seat = 0; start = 1; cycle();
    chk("t4_restart_state", state_o, 1);
    chk("t4_restart_time", time_left, TLIM);
    chk("t4_restart_tasks", tasks_completed, 0);

    // Final tick coinciding with the third door cycle.
    run(37);
    in_door = 1; run(3);
    chk("t5_timeout_beats_dwell", state_o, 4);
    in_door = 0; start = 1; cycle();
    in_door = 1; run(3);
    in_door = 0; run(36);
    task_done = 1; cycle();
    chk("t5_timeout_beats_done", state_o, 4);

    // Asynchronous reset mid-TASK.
    start = 1; cycle();
    in_door = 1; run(3);
    chk("t6_in_task", state_o, 2);
    in_door = 0;
    #2 rst_n = 0;
    #1;
    chk("t6_rst_state", state_o, 0);
    chk("t6_rst_time", time_left, TLIM);
    chk("t6_rst_tasks", tasks_completed, 0);
    chk("t6_rst_outs", {sprite_en, task_enable, win, lose}, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    start = 1; cycle();
    chk("t6_after_start", state_o, 1);

    // Random traffic.
    repeat (600) begin
      if ($urandom_range(3) == 0) in_door = ~in_door;
      if ($urandom_range(4) == 0) in_seat = ~in_seat;
      task_done = ($urandom_range(5) == 0);
      start     = ($urandom_range(30) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
